// File: rtl/rveven_parity_pkg.sv
// Shared definitions for the even-parity generator: segment width,
// the 16-bit parity function and the derived-size helpers.
package rveven_parity_pkg;

    localparam int PAR_SEG_W = 16;

    // Even parity: the XOR of the segment, so segment ^ parity reduces to 0.
    function automatic logic even_parity16(input logic [15:0] seg);
        return ^seg;
    endfunction

    // Number of 16-bit segments in a data word.
    function automatic int seg_count(input int data_width);
        return data_width / PAR_SEG_W;
    endfunction

    // Width of a segment index; never narrower than one bit.
    function automatic int seg_idx_w(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/rveven_paritygen_seg.sv
// Combinational parity generator: one even-parity bit per 16-bit segment.
module rveven_paritygen_seg
    import rveven_parity_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int NSEG = seg_count(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [NSEG-1:0]       parity
);

    // Segment i covers data[16i+15:16i].
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        assign parity[i] = even_parity16(data[PAR_SEG_W*i +: PAR_SEG_W]);
    end

endmodule

// File: rtl/rveven_paritygen_pipe.sv
// Even-parity generator with a registered valid/ready output stage.
// A main register drives out_* and a single skid register absorbs the beat
// accepted while main is stalled, so in_ready depends only on skid state.
// DATA_WIDTH must be a multiple of 16 and at least 16.
//
// Handshake: a beat moves when valid & ready are both high at a rising
// clock edge; once out_valid is high, out_data/out_parity stay stable
// until the beat is taken, and beats leave in the order they arrived.
module rveven_paritygen_pipe
    import rveven_parity_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int NSEG = seg_count(DATA_WIDTH),
    localparam int SEGW = seg_idx_w(NSEG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NSEG-1:0]       out_parity,
    input  logic                  inj_arm,
    input  logic [SEGW-1:0]       inj_seg,
    output logic                  inj_pending,
    output logic [15:0]           gen_count
);

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [NSEG-1:0]       main_par;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [NSEG-1:0]       skid_par;
    logic                  inj_pending_q;
    logic [SEGW-1:0]       inj_seg_q;
    logic [15:0]           gen_count_q;

    logic [NSEG-1:0]       seg_par;
    logic [NSEG-1:0]       inj_mask;
    logic [NSEG-1:0]       in_par;
    logic                  accept;
    logic                  drain;
    logic                  arm_ok;

    rveven_paritygen_seg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_seg (
        .data   (in_data),
        .parity (seg_par)
    );

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;
    assign arm_ok = inj_arm & ({1'b0, inj_seg} < (SEGW + 1)'(NSEG));

    // Parity of the incoming beat, with the armed segment's bit inverted.
    always_comb begin
        inj_mask = '0;
        if (inj_pending_q) begin
            inj_mask = NSEG'(1) << inj_seg_q;
        end
        in_par = seg_par ^ inj_mask;
    end

    // Main/skid storage: skid refills main on drain, otherwise the input
    // goes to main if it is free (or freeing) and to skid if main is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_par   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_par   <= '0;
        end else begin
            if (drain) begin
                if (skid_valid) begin
                    main_data  <= skid_data;
                    main_par   <= skid_par;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_data <= in_data;
                    main_par  <= in_par;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                if (main_valid) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                    skid_par   <= in_par;
                end else begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                    main_par   <= in_par;
                end
            end
        end
    end

    // Injection arm: consumed by an accept, a valid arm (re)sets it after that.
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_pending_q <= 1'b0;
            inj_seg_q     <= '0;
        end else begin
            if (accept) begin
                inj_pending_q <= 1'b0;
            end
            if (arm_ok) begin
                inj_pending_q <= 1'b1;
                inj_seg_q     <= inj_seg;
            end
        end
    end

    // Saturating count of output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_count_q <= '0;
        end else if (drain && (gen_count_q != 16'hFFFF)) begin
            gen_count_q <= gen_count_q + 16'd1;
        end
    end

    assign in_ready    = ~skid_valid;
    assign out_valid   = main_valid;
    assign out_data    = main_data;
    assign out_parity  = main_par;
    assign inj_pending = inj_pending_q;
    assign gen_count   = gen_count_q;

endmodule
